// File: rtl/pipe_skid_stage.sv
// Purpose : parametrised inter-stage pipeline register with a 2-entry skid buffer and a valid/ready handshake.
// Latency : 1 clk from an accepted input to out_valid; strict FIFO order; occupancy and stall-cycle status outputs.
// Backpr. : in_ready is registered (next occupancy < 2), so out_ready has no combinational path to in_ready.
module pipe_skid_stage #(
  parameter int DATA_W      = 64,
  parameter int CTRL_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_cnt_clr
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Main register drives the outputs; skid register holds the second entry.
  logic [1:0]             r_occ;
  logic                   r_out_valid;
  logic [DATA_W-1:0]      r_main_data;
  logic [CTRL_W-1:0]      r_main_ctrl;
  logic [DATA_W-1:0]      r_skid_data;
  logic [CTRL_W-1:0]      r_skid_ctrl;
  logic                   r_in_ready;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic                   w_accept;
  logic                   w_drain;
  logic                   w_stall;
  logic [1:0]             w_occ_nxt;
  logic                   w_out_valid_nxt;
  logic [DATA_W-1:0]      w_main_data_nxt;
  logic [CTRL_W-1:0]      w_main_ctrl_nxt;
  logic [DATA_W-1:0]      w_skid_data_nxt;
  logic [CTRL_W-1:0]      w_skid_ctrl_nxt;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;
  assign w_stall  = r_out_valid & ~out_ready;

  // Next-state of the buffer, selected by current occupancy; a bubble zeroes the main entry.
  always_comb begin
    w_occ_nxt       = r_occ;
    w_out_valid_nxt = r_out_valid;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    case (r_occ)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_occ_nxt       = OCC_ONE;
          w_out_valid_nxt = 1'b1;
          w_main_data_nxt = in_data;
          w_main_ctrl_nxt = in_ctrl;
        end
      end
      OCC_ONE: begin
        if (w_accept && w_drain) begin
          w_main_data_nxt = in_data;
          w_main_ctrl_nxt = in_ctrl;
        end else if (w_accept) begin
          w_occ_nxt       = OCC_TWO;
          w_skid_data_nxt = in_data;
          w_skid_ctrl_nxt = in_ctrl;
        end else if (w_drain) begin
          w_occ_nxt       = OCC_EMPTY;
          w_out_valid_nxt = 1'b0;
          w_main_data_nxt = '0;
          w_main_ctrl_nxt = '0;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only a drain can move the state.
        if (w_drain) begin
          w_occ_nxt       = OCC_ONE;
          w_main_data_nxt = r_skid_data;
          w_main_ctrl_nxt = r_skid_ctrl;
          w_skid_data_nxt = '0;
          w_skid_ctrl_nxt = '0;
        end
      end
      default: begin
        w_occ_nxt       = OCC_EMPTY;
        w_out_valid_nxt = 1'b0;
        w_main_data_nxt = '0;
        w_main_ctrl_nxt = '0;
        w_skid_data_nxt = '0;
        w_skid_ctrl_nxt = '0;
      end
    endcase
  end

  // Buffer registers: reset and flush both empty the stage; flush drops this cycle's input too.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ       <= OCC_EMPTY;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      r_occ       <= w_occ_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_in_ready  <= (w_occ_nxt != OCC_TWO);
    end
  end

  // Saturating stall-cycle counter; clear beats increment, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset || stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign occupancy = r_occ;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage (STALL_CNT_W=3 so saturation is reachable).
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Expected values are hand-derived from the handshake rules.
module tb_pipe_skid_stage;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 5;
  localparam int SCW    = 3;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_ready;
  logic [1:0]        occupancy;
  logic [SCW-1:0]    stall_cnt;
  logic              stall_cnt_clr;

  int n_assert;
  int n_fail;

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_CNT_W(SCW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .stall_cnt    (stall_cnt),
    .stall_cnt_clr(stall_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_occ"},   64'(occupancy), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"},  out_data,       64'd0);
    chk({tag, "_ctrl"},  64'(out_ctrl),  64'd0);
    chk({tag, "_rdy"},   64'(in_ready),  64'd1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b1; stall_cnt_clr = 1'b0;
    step();
    step();
    chk_empty("reset");
    chk("reset_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // 1. single transfer
    in_valid = 1'b1; in_data = 64'h1234; in_ctrl = 5'b10110;
    step();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data",  out_data,       64'h1234);
    chk("t1_ctrl",  64'(out_ctrl),  64'b10110);
    chk("t1_occ",   64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step();
    chk_empty("t1_after");

    // 2. backpressure fill
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA; in_ctrl = 5'd1;
    step();
    chk("t2a_occ",   64'(occupancy), 64'd1);
    chk("t2a_data",  out_data,       64'hA);
    chk("t2a_rdy",   64'(in_ready),  64'd1);
    chk("t2a_stall", 64'(stall_cnt), 64'd0);
    in_data = 64'hB; in_ctrl = 5'd2;
    step();
    chk("t2b_occ",   64'(occupancy), 64'd2);
    chk("t2b_data",  out_data,       64'hA);
    chk("t2b_rdy",   64'(in_ready),  64'd0);
    chk("t2b_stall", 64'(stall_cnt), 64'd1);
    in_data = 64'hC; in_ctrl = 5'd3;
    step();
    chk("t2c_occ",   64'(occupancy), 64'd2);
    chk("t2c_data",  out_data,       64'hA);
    chk("t2c_ctrl",  64'(out_ctrl),  64'd1);
    chk("t2c_rdy",   64'(in_ready),  64'd0);
    chk("t2c_stall", 64'(stall_cnt), 64'd2);

    // 3. drain order A (already shown), B, C
    out_ready = 1'b1;
    step();
    chk("t3b_data",  out_data,       64'hB);
    chk("t3b_ctrl",  64'(out_ctrl),  64'd2);
    chk("t3b_occ",   64'(occupancy), 64'd1);
    chk("t3b_rdy",   64'(in_ready),  64'd1);
    chk("t3b_stall", 64'(stall_cnt), 64'd2);
    step();
    chk("t3c_data",  out_data,       64'hC);
    chk("t3c_ctrl",  64'(out_ctrl),  64'd3);
    chk("t3c_occ",   64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step();
    chk_empty("t3_end");

    // 4. simultaneous accept and drain, data 1..8
    in_valid = 1'b1; in_data = 64'd1; in_ctrl = 5'd1;
    step();
    chk("t4_data1", out_data,       64'd1);
    chk("t4_occ1",  64'(occupancy), 64'd1);
    for (int i = 2; i <= 8; i++) begin
      in_data = 64'(i); in_ctrl = 5'(i);
      step();
      chk($sformatf("t4_data%0d", i), out_data,       64'(i));
      chk($sformatf("t4_occ%0d", i),  64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk_empty("t4_end");

    // 5. flush while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h51; in_ctrl = 5'd1;
    step();
    in_data = 64'h52; in_ctrl = 5'd2;
    step();
    chk("t5_occ_full", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 64'hFF; in_ctrl = 5'b11111;
    step();
    chk_empty("t5_flush");
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_empty("t5_post");

    // 6. stall counter saturation and clear
    stall_cnt_clr = 1'b1;
    step();
    chk("t6_clr0", 64'(stall_cnt), 64'd0);
    stall_cnt_clr = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h61; in_ctrl = 5'd4;
    step();
    chk("t6_occ",    64'(occupancy), 64'd1);
    chk("t6_stall0", 64'(stall_cnt), 64'd0);
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t6_stall%0d", k), 64'(stall_cnt), (k < 7) ? 64'(k) : 64'd7);
    end
    chk("t6_hold_data", out_data, 64'h61);
    stall_cnt_clr = 1'b1;
    step();
    chk("t6_clr", 64'(stall_cnt), 64'd0);
    stall_cnt_clr = 1'b0;
    step();
    chk("t6_restart", 64'(stall_cnt), 64'd1);

    // reset mid-stall, inputs ignored during the reset cycle
    reset = 1'b1; in_valid = 1'b1; in_data = 64'h77; in_ctrl = 5'b11111;
    step();
    chk_empty("t6_reset");
    chk("t6_reset_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    chk_empty("t6_reset_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised inter-stage pipeline register. It is the successor to the fixed-width EX/MEM latch and is used between EX→MEM and MEM→WB.
- Replaces the always-load latch with a 2-entry skid buffer that has a valid/ready handshake, so downstream can stall the stage without combinational ready paths.
- Keeps the synchronous flush and bubble semantics: control bits read zero whenever the output is not valid.
- Adds occupancy and saturating stall-cycle status for hazard-unit debug.

Parameters:
- DATA_W, 64: payload width (ALU result, store data, branch target, rd packed by the parent).
- CTRL_W, 5: control-bit width (Branch, MemRead, MemtoReg, MemWrite, RegWrite); forced to 0 on bubbles.
- STALL_CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all held entries and the input offered this cycle.
- in_valid  in  1  upstream entry valid.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_ready  out  1  registered; stage can accept this cycle.
- out_valid  out  1  registered; head entry valid.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control bits; 0 when out_valid=0.
- out_ready  in  1  downstream accepts head.
- occupancy  out  2  held entries: 0, 1 or 2.
- stall_cnt  out  STALL_CNT_W  saturating count of out_valid & !out_ready cycles.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset values, with priority reset > flush > normal:
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, in_ready=1.
  - Skid register is cleared to 0.
  - Inputs are ignored in the reset cycle.
- Event definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- State is set by occupancy: EMPTY(0), ONE(1), TWO(2). The main register drives out_*; the skid register holds the second entry.
- EMPTY:
  - accept → ONE, main←in, latency 1 clk.
  - otherwise stay.
- ONE:
  - accept & drain → ONE, main←in.
  - accept & !drain → TWO, skid←in, main held.
  - !accept & drain → EMPTY, main data/ctrl←0.
  - neither → hold.
- TWO:
  - in_ready=0, so accept cannot occur.
  - drain → ONE, main←skid, skid←0.
  - otherwise hold both entries.
- in_ready next = (next occupancy < 2). It is registered, so there is no comb path from out_ready to in_ready.
- Ordering is strict FIFO. No entry is lost or duplicated under any out_ready pattern.
- out_ctrl = 0 whenever out_valid=0. Bubble control bits must never be non-zero.
- Flush:
  - Next cycle: occupancy=0, out_valid=0, out_data/out_ctrl=0, skid=0, in_ready=1.
  - An in_valid asserted in the flush cycle is dropped even if in_ready=1. Upstream is flushed by the same hazard-unit signal.
  - A drain in the flush cycle still completes downstream; the entry is removed.
  - stall_cnt is not affected by flush.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^STALL_CNT_W-1 with no wrap.
  - stall_cnt_clr → 0 next cycle, taking priority over increment.
  - reset also clears it.
- Payload and control are captured together. There are no per-field enables.

Test Plan:
1. Single transfer:
   - Stimulus: after reset, in_valid=1, in_data=64'h1234, in_ctrl=5'b10110 for 1 clk, out_ready=1.
   - Required: next cycle out_valid=1, out_data=64'h1234, out_ctrl=5'b10110, occupancy=1; following cycle out_valid=0, out_ctrl=0.
2. Backpressure fill:
   - Stimulus: out_ready=0, send A=64'hA, B=64'hB, then offer C.
   - Required: occupancy 1 then 2; in_ready=0 after B; C is not accepted; out_data stays 64'hA; stall_cnt increments each cycle.
3. Drain order:
   - Stimulus: from scenario 2, out_ready=1 with in_valid=1 carrying C.
   - Required: out_data sequence A, B, C on consecutive cycles; nothing lost or duplicated; in_ready returns to 1 one cycle after leaving TWO.
4. Simultaneous accept and drain:
   - Stimulus: in ONE, in_valid=1 and out_ready=1 every cycle with data 1..8.
   - Required: occupancy stays 1; output is 1..8, one per cycle.
5. Flush in TWO:
   - Stimulus: occupancy=2, flush=1 with in_valid=1, in_ctrl=5'b11111.
   - Required: next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1; the flushed input never appears at the output.
6. Stall counter:
   - Stimulus: STALL_CNT_W=3, hold out_valid=1 with out_ready=0 for 10 cycles, then pulse stall_cnt_clr.
   - Required: stall_cnt reaches 7 and holds at 7; it reads 0 the cycle after the clear.
   - Also: reset asserted mid-stall gives all reset values on the next cycle.
